// File: rtl/rob_pkg.sv
// Shared constants, entry layout and pointer helper for the reorder buffer.
package rob_pkg;

    localparam int ROB_SIZE        = 32;
    localparam int ROB_SIZE_CLOG   = 5;
    localparam int ROB_MAX_RETIRE  = 2;
    localparam int ISSUE_WIDTH_MAX = 2;
    localparam int NUM_WB          = 2;
    localparam int DATA_LEN        = 32;
    localparam int SRC_LEN         = 5;

    // Pointers carry one extra wrap bit above the entry index.
    localparam int PTR_W       = ROB_SIZE_CLOG + 1;
    localparam int RET_CNT_W   = $clog2(ROB_MAX_RETIRE + 1);
    localparam int ALLOC_CNT_W = $clog2(ISSUE_WIDTH_MAX + 1);

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                rfWrite;
        logic [SRC_LEN-1:0]  rd;
        logic [DATA_LEN-1:0] data;
    } rob_entry_t;

    // Entry index reached by stepping 'off' slots past a wrap-bit pointer.
    function automatic logic [ROB_SIZE_CLOG-1:0] robIdx(input logic [PTR_W-1:0] ptr,
                                                        input int off);
        logic [PTR_W-1:0] sum;
        sum = ptr + PTR_W'(off);
        return sum[ROB_SIZE_CLOG-1:0];
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Leading-ones counter over the oldest entries: a lane retires only when it
// and every older lane in the window are both valid and done.
module rob_retire_sel
    import rob_pkg::*;
(
    input  logic [ROB_MAX_RETIRE-1:0] valid_i,
    input  logic [ROB_MAX_RETIRE-1:0] done_i,
    output logic [ROB_MAX_RETIRE-1:0] sel_o,
    output logic [RET_CNT_W-1:0]      n_o
);

    logic run;

    // Walk from the head lane outward; the first not-ready lane stops the run.
    always_comb begin
        run   = 1'b1;
        sel_o = '0;
        n_o   = '0;
        for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
            run      = run & valid_i[i] & done_i[i];
            sel_o[i] = run;
            n_o      = n_o + RET_CNT_W'(run);
        end
    end

endmodule

// File: rtl/rob_retire_unit.sv
// Reorder buffer: in-order allocation, out-of-order completion, and in-order
// retirement of up to ROB_MAX_RETIRE entries per cycle through registered
// retire ports feeding the register file.
module rob_retire_unit
    import rob_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    instr_val_ar,
    input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]       rd_ar,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    rfWrite_ar,
    output logic                                          alloc_rdy,
    output logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] robid_alloc,
    input  logic [NUM_WB-1:0]                             wb_val,
    input  logic [NUM_WB-1:0][ROB_SIZE_CLOG-1:0]          wb_robid,
    input  logic [NUM_WB-1:0][DATA_LEN-1:0]               wb_data,
    output logic [ROB_MAX_RETIRE-1:0]                     val_ret,
    output logic [ROB_MAX_RETIRE-1:0]                     rfWrite_ret,
    output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]        rd_ret,
    output logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0]  robid_ret,
    output logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0]       wb_data_ret,
    output logic                                          rob_empty,
    output logic                                          rob_full,
    output logic [ROB_SIZE_CLOG:0]                        rob_count
);

    rob_entry_t mem_q [ROB_SIZE];
    rob_entry_t mem_d [ROB_SIZE];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count_q, count_d;

    logic [ALLOC_CNT_W-1:0] allocCnt;
    logic                   allocFire;

    logic [ROB_MAX_RETIRE-1:0] headValid;
    logic [ROB_MAX_RETIRE-1:0] headDone;
    logic [ROB_MAX_RETIRE-1:0] retSel;
    logic [RET_CNT_W-1:0]      retN;

    logic [ROB_MAX_RETIRE-1:0]                    valRet_q, valRet_d;
    logic [ROB_MAX_RETIRE-1:0]                    rfWriteRet_q, rfWriteRet_d;
    logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]       rdRet_q, rdRet_d;
    logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0] robidRet_q, robidRet_d;
    logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0]      dataRet_q, dataRet_d;

    // Allocation gating uses the pre-retire count, so a same-cycle retire never
    // opens room for a same-cycle allocation.
    assign alloc_rdy = (PTR_W'(ROB_SIZE) - count_q) >= PTR_W'(ISSUE_WIDTH_MAX);
    assign allocFire = alloc_rdy & ~flush;

    // Compact valid lanes in lane order: each lane gets tail plus the number of
    // valid lanes below it.
    always_comb begin
        allocCnt = '0;
        for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
            robid_alloc[k] = tail_q[ROB_SIZE_CLOG-1:0] + ROB_SIZE_CLOG'(allocCnt);
            allocCnt       = allocCnt + ALLOC_CNT_W'(instr_val_ar[k]);
        end
    end

    // Present the registered valid/done bits of the oldest entries to the selector.
    always_comb begin
        for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
            headValid[i] = mem_q[robIdx(head_q, i)].valid;
            headDone[i]  = mem_q[robIdx(head_q, i)].done;
        end
    end

    rob_retire_sel u_sel (
        .valid_i (headValid),
        .done_i  (headDone),
        .sel_o   (retSel),
        .n_o     (retN)
    );

    // Next-state: flush wins outright; otherwise apply writeback, then clear
    // retiring entries, then install new allocations into free slots.
    always_comb begin
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        valRet_d     = '0;
        rfWriteRet_d = '0;
        rdRet_d      = '0;
        robidRet_d   = '0;
        dataRet_d    = '0;

        if (flush) begin
            for (int j = 0; j < ROB_SIZE; j++) begin
                mem_d[j] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Highest port first so that port 0 has the final say on a shared target.
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_val[p] && mem_q[wb_robid[p]].valid) begin
                    mem_d[wb_robid[p]].done = 1'b1;
                    mem_d[wb_robid[p]].data = wb_data[p];
                end
            end

            for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
                if (retSel[i]) begin
                    valRet_d[i]               = 1'b1;
                    rfWriteRet_d[i]           = mem_q[robIdx(head_q, i)].rfWrite;
                    rdRet_d[i]                = mem_q[robIdx(head_q, i)].rd;
                    robidRet_d[i]             = robIdx(head_q, i);
                    dataRet_d[i]              = mem_q[robIdx(head_q, i)].data;
                    mem_d[robIdx(head_q, i)]  = '0;
                end
            end

            if (allocFire) begin
                for (int k = 0; k < ISSUE_WIDTH_MAX; k++) begin
                    if (instr_val_ar[k]) begin
                        mem_d[robid_alloc[k]].valid   = 1'b1;
                        mem_d[robid_alloc[k]].done    = 1'b0;
                        mem_d[robid_alloc[k]].rfWrite = rfWrite_ar[k];
                        mem_d[robid_alloc[k]].rd      = rd_ar[k];
                        mem_d[robid_alloc[k]].data    = '0;
                    end
                end
                tail_d = tail_q + PTR_W'(allocCnt);
            end

            head_d  = head_q + PTR_W'(retN);
            count_d = count_q + (allocFire ? PTR_W'(allocCnt) : '0) - PTR_W'(retN);
        end
    end

    // State and retire-port registers; reset behaves like a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < ROB_SIZE; j++) begin
                mem_q[j] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valRet_q     <= '0;
            rfWriteRet_q <= '0;
            rdRet_q      <= '0;
            robidRet_q   <= '0;
            dataRet_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valRet_q     <= valRet_d;
            rfWriteRet_q <= rfWriteRet_d;
            rdRet_q      <= rdRet_d;
            robidRet_q   <= robidRet_d;
            dataRet_q    <= dataRet_d;
        end
    end

    assign val_ret     = valRet_q;
    assign rfWrite_ret = rfWriteRet_q;
    assign rd_ret      = rdRet_q;
    assign robid_ret   = robidRet_q;
    assign wb_data_ret = dataRet_q;
    assign rob_count   = count_q;
    assign rob_empty   = (count_q == '0);
    assign rob_full    = (count_q == PTR_W'(ROB_SIZE));

endmodule
